minimax_rf_ctrl: RTL and testbench

MINIMAX_RF_CTRL -- requirements
Module: minimax_rf_ctrl

---
 rtl/minimax_pkg.sv | 23 ++
 rtl/minimax_rf_wbuf.sv | 46 ++++
 rtl/minimax_rf_ctrl.sv | 140 ++++++++++++++
 tb/tb_minimax_rf_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimax_pkg.sv
// Shared types and sizes for the minimax register-file write controller.
package minimax_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

  // Highest register index; the clear sweep stops here instead of wrapping to x0.
  localparam reg_addr_t LAST_REG = reg_addr_t'(NUM_REGS - 1);

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/minimax_rf_wbuf.sv
// One-entry valid/ready buffer for load writebacks, with dequeue and flush.
module minimax_rf_wbuf
  import minimax_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]       in_data,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic [XLEN-1:0]       out_data,
  input  logic                  deq,
  input  logic                  flush
);

  logic      valid_q;
  reg_addr_t addr_q;
  xword_t    data_q;

  // No same-cycle refill: a freed slot accepts again only on the following cycle.
  assign in_ready  = en && !valid_q;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (deq || flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      addr_q <= in_addr;
      data_q <= in_data;
    end
  end

endmodule

// File: rtl/minimax_rf_ctrl.sv
// Register-file write-port controller: post-reset clear, then cpu/load/debug arbitration.
// MINIMAX_RF_CLEAR_EN enables the zeroing sweep of x1..x31; otherwise CLEAR lasts one idle cycle.
module minimax_rf_ctrl
  import minimax_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_we,
  input  logic [REG_ADDR_W-1:0] cpu_addr,
  input  logic [XLEN-1:0]       cpu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]       dbg_wdata,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addrD,
  output logic [XLEN-1:0]       rf_new_value,
  input  logic [XLEN-1:0]       rf_rD,
  output logic                  busy
);

  rf_state_e state_q, state_d;

  logic      buf_valid;
  logic      buf_deq;
  logic      buf_flush;
  reg_addr_t buf_addr;
  xword_t    buf_data;
  logic      dbg_grant;

`ifdef MINIMAX_RF_CLEAR_EN
  reg_addr_t clr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_q <= reg_addr_t'(1);
    end else if (state_q == CLEAR && clr_cnt_q != LAST_REG) begin
      clr_cnt_q <= clr_cnt_q + reg_addr_t'(1);
    end
  end
`endif

  minimax_rf_wbuf u_wbuf (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == RUN),
    .in_valid (ld_valid),
    .in_ready (ld_ready),
    .in_addr  (ld_addr),
    .in_data  (ld_data),
    .out_valid(buf_valid),
    .out_addr (buf_addr),
    .out_data (buf_data),
    .deq      (buf_deq),
    .flush    (buf_flush)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: begin
`ifdef MINIMAX_RF_CLEAR_EN
        if (clr_cnt_q == LAST_REG) begin
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // One write per cycle: cpu beats the buffered load, which beats debug.
  always_comb begin
    busy         = 1'b0;
    rf_we        = 1'b0;
    rf_addrD     = cpu_addr;
    rf_new_value = cpu_data;
    buf_deq      = 1'b0;
    buf_flush    = 1'b0;
    dbg_grant    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy = 1'b1;
`ifdef MINIMAX_RF_CLEAR_EN
        rf_we        = 1'b1;
        rf_addrD     = clr_cnt_q;
        rf_new_value = '0;
`endif
      end
      RUN: begin
        if (cpu_we) begin
          rf_we     = !is_x0(cpu_addr);
          // A same-address cpu write supersedes the older buffered load.
          buf_flush = buf_valid && (buf_addr == cpu_addr);
        end else if (buf_valid) begin
          rf_we        = !is_x0(buf_addr);
          rf_addrD     = buf_addr;
          rf_new_value = buf_data;
          buf_deq      = 1'b1;
        end else if (dbg_req && !dbg_ack) begin
          dbg_grant    = 1'b1;
          rf_we        = dbg_we && !is_x0(dbg_addr);
          rf_addrD     = dbg_addr;
          rf_new_value = dbg_wdata;
        end
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= dbg_grant;
      if (dbg_grant && !dbg_we) begin
        dbg_rdata <= is_x0(dbg_addr) ? '0 : rf_rD;
      end
    end
  end

endmodule

// File: tb/tb_minimax_rf_ctrl.sv
// Self-checking bench for minimax_rf_ctrl; follows MINIMAX_RF_CLEAR_EN like the design.
module tb_minimax_rf_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        rf_we;
  logic [4:0]  rf_addrD;
  logic [31:0] rf_new_value;
  logic [31:0] rf_rD;
  logic        busy;

  logic [31:0] mem [32];
  logic [31:0] ref_rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file behind the write port; x0 reads back garbage so the design must mask it.
  always @(posedge clk) if (rf_we) mem[rf_addrD] <= rf_new_value;
  assign rf_rD = (rf_addrD == 5'd0) ? 32'hBAD0_0BAD : mem[rf_addrD];

  minimax_rf_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_we(rf_we), .rf_addrD(rf_addrD), .rf_new_value(rf_new_value), .rf_rD(rf_rD),
    .busy(busy)
  );

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack: got %b want 0", dbg_ack); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_dbg_rdata: got %h want 0", dbg_rdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    do_reset();
`ifdef MINIMAX_RF_CLEAR_EN
    for (int i = 1; i <= 31; i++) begin
      cpu_we = 1'b1; cpu_addr = 5'($urandom); cpu_data = $urandom;
      ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h9999;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h4444;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy[%0d]: got %b want 1", i, busy); end
      checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'(i) || rf_new_value !== 32'h0)
        begin errors++; $display("FAIL clear_write[%0d]: got we=%b a=%0d d=%h want we=1 a=%0d d=0", i, rf_we, rf_addrD, rf_new_value, i); end
      checks++; if (ld_ready !== 1'b0 || dbg_ack !== 1'b0)
        begin errors++; $display("FAIL clear_gate[%0d]: got ld_ready=%b dbg_ack=%b want 0/0", i, ld_ready, dbg_ack); end
      @(negedge clk);
    end
`else
    cpu_we = 1'b1; cpu_addr = 5'd4; cpu_data = 32'h4444;
    #1;
    checks++; if (busy !== 1'b1 || rf_we !== 1'b0)
      begin errors++; $display("FAIL clear_cycle: got busy=%b we=%b want busy=1 we=0", busy, rf_we); end
    @(negedge clk);
`endif
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy: got %b want 0", busy); end
    checks++; if (rf_we !== 1'b0 || ld_ready !== 1'b1 || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL clear_done_idle: got we=%b ld_ready=%b ack=%b want 0/1/0", rf_we, ld_ready, dbg_ack); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b0 || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL clear_nothing_leaked: got we=%b ack=%b want 0/0", rf_we, dbg_ack); end
`ifdef MINIMAX_RF_CLEAR_EN
    checks++; if (mem[31] !== 32'h0 || mem[1] !== 32'h0)
      begin errors++; $display("FAIL clear_mem: got x1=%h x31=%h want 0/0", mem[1], mem[31]); end
`endif
    @(negedge clk);
  endtask

  task automatic test_cpu_then_load();
    cpu_we = 1'b1; cpu_addr = 5'd5; cpu_data = 32'hDEAD_BEEF;
    ld_valid = 1'b1; ld_addr = 5'd6; ld_data = 32'h1234_5678;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd5 || rf_new_value !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL cpu_write: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_addrD, rf_new_value); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_N: got %b want 1", ld_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd6 || rf_new_value !== 32'h1234_5678)
      begin errors++; $display("FAIL load_write: got we=%b a=%0d d=%h want 1/6/12345678", rf_we, rf_addrD, rf_new_value); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_N1: got %b want 0", ld_ready); end
    @(negedge clk);
    #1;
    checks++; if (ld_ready !== 1'b1 || rf_we !== 1'b0)
      begin errors++; $display("FAIL ld_ready_N2: got ready=%b we=%b want 1/0", ld_ready, rf_we); end
    checks++; if (mem[5] !== 32'hDEAD_BEEF || mem[6] !== 32'h1234_5678)
      begin errors++; $display("FAIL cpu_load_mem: got x5=%h x6=%h want deadbeef/12345678", mem[5], mem[6]); end
    @(negedge clk);
  endtask

  task automatic test_load_discard_and_x0();
    cpu_we = 1'b1; cpu_addr = 5'd9; cpu_data = 32'h99;
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h77;
    #1;
    @(negedge clk);
    ld_valid = 1'b0; cpu_addr = 5'd7; cpu_data = 32'hA5;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd7 || rf_new_value !== 32'hA5 || ld_ready !== 1'b0)
      begin errors++; $display("FAIL discard_cpu: got we=%b a=%0d d=%h rdy=%b want 1/7/a5/0", rf_we, rf_addrD, rf_new_value, ld_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rf_we !== 1'b0 || ld_ready !== 1'b1)
      begin errors++; $display("FAIL discard_after: got we=%b rdy=%b want 0/1", rf_we, ld_ready); end
    checks++; if (mem[7] !== 32'hA5) begin errors++; $display("FAIL discard_mem: got %h want a5", mem[7]); end
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hFF;
    @(negedge clk);
    idle_inputs(); cpu_addr = 5'd13; cpu_data = 32'h13;
    #1;
    checks++; if (rf_we !== 1'b0 || ld_ready !== 1'b0)
      begin errors++; $display("FAIL x0_load: got we=%b rdy=%b want 0/0", rf_we, ld_ready); end
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 5'd0; cpu_data = 32'h1;
    #1;
    checks++; if (ld_ready !== 1'b1 || rf_we !== 1'b0)
      begin errors++; $display("FAIL x0_cpu: got rdy=%b we=%b want 1/0", ld_ready, rf_we); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_debug();
    cpu_we = 1'b1; cpu_addr = 5'd3; cpu_data = 32'h55;
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 5'd17;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_addrD !== 5'd3 || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL dbg_rd_grant: got we=%b a=%0d ack=%b want 0/3/0", rf_we, rf_addrD, dbg_ack); end
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h55)
      begin errors++; $display("FAIL dbg_rd_ack: got ack=%b rdata=%h want 1/55", dbg_ack, dbg_rdata); end
    checks++; if (rf_addrD !== 5'd17) begin errors++; $display("FAIL dbg_no_regrant: got a=%0d want 17", rf_addrD); end
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h55)
      begin errors++; $display("FAIL dbg_hold: got ack=%b rdata=%h want 0/55", dbg_ack, dbg_rdata); end
    @(negedge clk);
    dbg_req = 1'b1; dbg_addr = 5'd0;
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h0)
      begin errors++; $display("FAIL dbg_rd_x0: got ack=%b rdata=%h want 1/0", dbg_ack, dbg_rdata); end
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd10 || rf_new_value !== 32'hCAFE_F00D || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL dbg_wr_grant: got we=%b a=%0d d=%h ack=%b want 1/10/cafef00d/0", rf_we, rf_addrD, rf_new_value, dbg_ack); end
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b1 || rf_we !== 1'b0)
      begin errors++; $display("FAIL dbg_wr_ack: got ack=%b we=%b want 1/0", dbg_ack, rf_we); end
    @(negedge clk);
    dbg_addr = 5'd0; dbg_wdata = 32'h1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL dbg_wr_x0: got we=%b want 0", rf_we); end
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h0 || mem[10] !== 32'hCAFE_F00D)
      begin errors++; $display("FAIL dbg_wr_x0_ack: got ack=%b rdata=%h x10=%h want 1/0/cafef00d", dbg_ack, dbg_rdata, mem[10]); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_debug_starve();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h1234_5678;
    for (int k = 0; k < 10; k++) begin
      cpu_we = 1'b1; cpu_addr = 5'(k + 1); cpu_data = $urandom;
      #1;
      checks++; if (dbg_ack !== 1'b0 || rf_addrD !== cpu_addr || rf_new_value !== cpu_data)
        begin errors++; $display("FAIL starve[%0d]: got ack=%b a=%0d d=%h want 0/%0d/%h", k, dbg_ack, rf_addrD, rf_new_value, cpu_addr, cpu_data); end
      @(negedge clk);
    end
    cpu_we = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_addrD !== 5'd12 || rf_new_value !== 32'h1234_5678 || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL starve_grant: got we=%b a=%0d d=%h ack=%b want 1/12/12345678/0", rf_we, rf_addrD, rf_new_value, dbg_ack); end
    @(negedge clk);
    #1;
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL starve_ack: got %b want 1", dbg_ack); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    cpu_we = 1'b1; cpu_addr = 5'd2; cpu_data = 32'h22;
    ld_valid = 1'b1; ld_addr = 5'd20; ld_data = 32'h2020;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd21; dbg_wdata = 32'h2121;
    @(negedge clk);
    ld_valid = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
`ifdef MINIMAX_RF_CLEAR_EN
    for (int i = 1; i < 12; i++) @(negedge clk);
    #1;
    checks++; if (rf_addrD !== 5'd12) begin errors++; $display("FAIL midclr_at12: got a=%0d want 12", rf_addrD); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      #1;
      checks++; if (busy !== 1'b1 || rf_we !== 1'b1 || rf_addrD !== 5'(i))
        begin errors++; $display("FAIL midclr_restart[%0d]: got busy=%b we=%b a=%0d want 1/1/%0d", i, busy, rf_we, rf_addrD, i); end
      @(negedge clk);
    end
`else
    #1;
    checks++; if (busy !== 1'b1 || rf_we !== 1'b0)
      begin errors++; $display("FAIL midclr_cycle: got busy=%b we=%b want 1/0", busy, rf_we); end
    @(negedge clk);
`endif
    #1;
    checks++; if (busy !== 1'b0 || rf_we !== 1'b0 || ld_ready !== 1'b1 || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL midclr_dropped: got busy=%b we=%b rdy=%b ack=%b want 0/0/1/0", busy, rf_we, ld_ready, dbg_ack); end
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b0 || dbg_ack !== 1'b0)
      begin errors++; $display("FAIL midclr_quiet: got we=%b ack=%b want 0/0", rf_we, dbg_ack); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        pv, ack_e, ld_took, ack_seen, exp_ready, exp_we, rd_grant, any_op;
    logic [4:0]  pa;
    logic [31:0] pd, rdata_e;
    do_reset();
`ifdef MINIMAX_RF_CLEAR_EN
    repeat (31) @(negedge clk);
`else
    @(negedge clk);
`endif
    for (int r = 1; r < 32; r++) begin
      cpu_we = 1'b1; cpu_addr = 5'(r); cpu_data = $urandom;
      ref_rf[r] = cpu_data;
      @(negedge clk);
    end
    idle_inputs();
    pv = 1'b0; pa = '0; pd = '0; ack_e = 1'b0; rdata_e = '0; ld_took = 1'b0; ack_seen = 1'b0;
    repeat (400) begin
      if (ld_valid && ld_took) ld_valid = 1'b0;
      if (!ld_valid && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b1; ld_addr = 5'($urandom); ld_data = $urandom;
      end
      if (dbg_req && ack_seen) dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      end
      cpu_we = 1'($urandom);
      cpu_addr = (pv && $urandom_range(0, 2) == 0) ? pa : 5'($urandom);
      cpu_data = $urandom;
      #1;
      exp_ready = !pv;
      exp_we = 1'b0; rd_grant = 1'b0; any_op = 1'b1;
      checks++; if (ld_ready !== exp_ready) begin errors++; $display("FAIL rnd_ld_ready: got %b want %b", ld_ready, exp_ready); end
      checks++; if (dbg_ack !== ack_e) begin errors++; $display("FAIL rnd_dbg_ack: got %b want %b", dbg_ack, ack_e); end
      checks++; if (dbg_rdata !== rdata_e) begin errors++; $display("FAIL rnd_dbg_rdata: got %h want %h", dbg_rdata, rdata_e); end
      if (cpu_we) begin
        exp_we = (cpu_addr != 5'd0);
        if (exp_we) ref_rf[cpu_addr] = cpu_data;
        if (pv && pa == cpu_addr) pv = 1'b0;
        ack_e = 1'b0;
        checks++; if (rf_we !== exp_we || rf_addrD !== cpu_addr || rf_new_value !== cpu_data)
          begin errors++; $display("FAIL rnd_cpu: got we=%b a=%0d d=%h want %b/%0d/%h", rf_we, rf_addrD, rf_new_value, exp_we, cpu_addr, cpu_data); end
      end else if (pv) begin
        exp_we = (pa != 5'd0);
        if (exp_we) ref_rf[pa] = pd;
        pv = 1'b0;
        ack_e = 1'b0;
        checks++; if (rf_we !== exp_we || (exp_we && (rf_addrD !== pa || rf_new_value !== pd)))
          begin errors++; $display("FAIL rnd_load: got we=%b a=%0d d=%h want %b/%0d/%h", rf_we, rf_addrD, rf_new_value, exp_we, pa, pd); end
      end else if (dbg_req && !ack_e) begin
        exp_we = dbg_we && (dbg_addr != 5'd0);
        rd_grant = !dbg_we;
        checks++; if (rf_we !== exp_we || rf_addrD !== dbg_addr || (exp_we && rf_new_value !== dbg_wdata))
          begin errors++; $display("FAIL rnd_dbg: got we=%b a=%0d d=%h want %b/%0d/%h", rf_we, rf_addrD, rf_new_value, exp_we, dbg_addr, dbg_wdata); end
        if (rd_grant) rdata_e = (dbg_addr == 5'd0) ? 32'h0 : ref_rf[dbg_addr];
        if (exp_we) ref_rf[dbg_addr] = dbg_wdata;
        ack_e = 1'b1;
      end else begin
        any_op = 1'b0;
        ack_e = 1'b0;
      end
      if (!any_op) begin
        checks++; if (rf_we !== 1'b0 || rf_addrD !== cpu_addr || rf_new_value !== cpu_data)
          begin errors++; $display("FAIL rnd_idle: got we=%b a=%0d d=%h want 0/%0d/%h", rf_we, rf_addrD, rf_new_value, cpu_addr, cpu_data); end
      end
      if (ld_valid && exp_ready) begin
        pv = 1'b1; pa = ld_addr; pd = ld_data;
      end
      ld_took = ld_valid && ld_ready;
      ack_seen = dbg_ack;
      @(negedge clk);
    end
    for (int r = 1; r < 32; r++) begin
      checks++; if (mem[r] !== ref_rf[r]) begin errors++; $display("FAIL rnd_rf[%0d]: got %h want %h", r, mem[r], ref_rf[r]); end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_clear();
    test_cpu_then_load();
    test_load_discard_and_x0();
    test_debug();
    test_debug_starve();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
